// File: rtl/sat_accum_16bit_pkg.sv
// Shared definitions for the saturating accumulator: datapath width,
// saturation limits and the handshake state encoding.
package sat_accum_16bit_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit two's-complement add/subtract with signed saturation.
// The wrapped sum is also exported so the caller can derive its own flags.
module addsub_16bit
  import sat_accum_16bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] raw
);

  logic [DATA_W-1:0] b_eff;
  logic              pos_ovf;
  logic              neg_ovf;

  // Subtraction is a + ~b + 1, so 0 - 0x8000 overflows positive and saturates.
  assign b_eff   = sub ? ~b : b;
  assign raw     = a + b_eff + {{(DATA_W-1){1'b0}}, sub};
  assign pos_ovf = !a[DATA_W-1] && !b_eff[DATA_W-1] &&  raw[DATA_W-1];
  assign neg_ovf =  a[DATA_W-1] &&  b_eff[DATA_W-1] && !raw[DATA_W-1];

  always_comb begin
    sum = raw;
    if (pos_ovf)      sum = SAT_MAX;
    else if (neg_ovf) sum = SAT_MIN;
  end

endmodule

// File: rtl/sat_accum_16bit.sv
// Saturating signed accumulator: accepts a sequence of add/sub beats ended by
// in_last, then presents the result with Z/N/V flags and a beat count.
module sat_accum_16bit
  import sat_accum_16bit_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_z,
  output logic              out_n,
  output logic              out_v,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               v_q, v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  sat_sum;
  logic [DATA_W-1:0]  raw_sum;
  logic               b_eff_sign;
  logic               step_ovf;
  logic               accept;

  addsub_16bit u_addsub (
    .a   (acc_q),
    .b   (in_data),
    .sub (in_sub),
    .sum (sat_sum),
    .raw (raw_sum)
  );

  // A step saturates when both effective operands share a sign the wrapped result lacks.
  assign b_eff_sign = in_sub ? ~in_data[DATA_W-1] : in_data[DATA_W-1];
  assign step_ovf   = (acc_q[DATA_W-1] == b_eff_sign) &&
                      (raw_sum[DATA_W-1] != acc_q[DATA_W-1]);

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = sat_sum;
          v_d     = v_q || step_ovf;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          v_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        v_d     = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_z     = (acc_q == '0);
  assign out_n     = acc_q[DATA_W-1];
  assign out_v     = v_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_sat_accum_16bit.sv
// Directed self-checking bench for sat_accum_16bit with hand-computed results.
module tb_sat_accum_16bit;

  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_sub;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_sum;
  logic              out_z;
  logic              out_n;
  logic              out_v;
  logic [CNT_W-1:0]  out_count;

  int n_checks = 0;
  int n_fail   = 0;

  sat_accum_16bit #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_v     (out_v),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; offers one beat across the next rising edge.
  task automatic send_beat(input logic [15:0] data, input logic sub, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_sub   = sub;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_sub   = 1'b1;
    in_last  = 1'b1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] sum, input logic z,
                              input logic n, input logic v, input logic [CNT_W-1:0] cnt);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " sum"},   32'(out_sum),   32'(sum));
    check({tag, " z"},     32'(out_z),     32'(z));
    check({tag, " n"},     32'(out_n),     32'(n));
    check({tag, " v"},     32'(out_v),     32'(v));
    check({tag, " count"}, 32'(out_count), 32'(cnt));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " idle valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle ready"}, 32'(in_ready),  32'd1);
    check({tag, " idle sum"},   32'(out_sum),   32'd0);
    check({tag, " idle count"}, 32'(out_count), 32'd0);
    check({tag, " idle v"},     32'(out_v),     32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst ready", 32'(in_ready),  32'd1);
    check("rst sum",   32'(out_sum),   32'd0);
    check("rst z",     32'(out_z),     32'd1);
    check("rst v",     32'(out_v),     32'd0);
    check("rst count", 32'(out_count), 32'd0);

    // Idle cycle with no valid must be ignored
    in_data = 16'h1234; in_last = 1'b1; in_sub = 1'b0;
    @(negedge clk);
    check("noval valid", 32'(out_valid), 32'd0);
    check("noval sum",   32'(out_sum),   32'd0);
    check("noval count", 32'(out_count), 32'd0);

    // 5 + 3
    send_beat(16'h0005, 1'b0, 1'b0);
    check("s1 mid valid", 32'(out_valid), 32'd0);
    check("s1 mid sum",   32'(out_sum),   32'h5);
    send_beat(16'h0003, 1'b0, 1'b1);
    check_result("s1", 16'h0008, 1'b0, 1'b0, 1'b0, 4'd2);
    release_result("s1");

    // Positive saturation
    send_beat(16'h7FF0, 1'b0, 1'b0);
    send_beat(16'h0020, 1'b0, 1'b1);
    check_result("s2", 16'h7FFF, 1'b0, 1'b0, 1'b1, 4'd2);
    release_result("s2");

    // 0 - 0x8000 single beat
    send_beat(16'h8000, 1'b1, 1'b1);
    check_result("s3", 16'h7FFF, 1'b0, 1'b0, 1'b1, 4'd1);
    release_result("s3");

    // -1 then +1 -> zero
    send_beat(16'h0001, 1'b1, 1'b0);
    check("s4 mid sum", 32'(out_sum), 32'hFFFF);
    check("s4 mid n",   32'(out_n),   32'd1);
    send_beat(16'h0001, 1'b0, 1'b1);
    check_result("s4", 16'h0000, 1'b1, 1'b0, 1'b0, 4'd2);
    release_result("s4");

    // Sticky V across a non-saturating step
    send_beat(16'h7FFF, 1'b0, 1'b0);
    send_beat(16'h0001, 1'b0, 1'b0);
    check("s5 mid sum", 32'(out_sum), 32'h7FFF);
    check("s5 mid v",   32'(out_v),   32'd1);
    send_beat(16'h0010, 1'b1, 1'b1);
    check_result("s5", 16'h7FEF, 1'b0, 1'b0, 1'b1, 4'd3);
    release_result("s5");

    // Negative saturation followed by backpressure
    send_beat(16'h8000, 1'b0, 1'b0);
    send_beat(16'h0001, 1'b1, 1'b1);
    check_result("s6", 16'h8000, 1'b0, 1'b1, 1'b1, 4'd2);
    in_valid = 1'b1; in_data = 16'h0100; in_sub = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp ready", 32'(in_ready), 32'd0);
      check_result("bp", 16'h8000, 1'b0, 1'b1, 1'b1, 4'd2);
    end
    in_valid = 1'b0;
    release_result("bp");

    // Beat counter holds at all-ones: 16 beats of +1
    for (int i = 0; i < 15; i++) send_beat(16'h0001, 1'b0, 1'b0);
    check("cnt mid count", 32'(out_count), 32'd15);
    send_beat(16'h0001, 1'b0, 1'b1);
    check_result("cnt", 16'h0010, 1'b0, 1'b0, 1'b0, 4'd15);
    release_result("cnt");

    // Reset mid-sequence takes priority over a simultaneous beat
    send_beat(16'h0010, 1'b0, 1'b0);
    send_beat(16'h0020, 1'b0, 1'b0);
    check("mr mid sum", 32'(out_sum), 32'h30);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0100; in_sub = 1'b0; in_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr valid", 32'(out_valid), 32'd0);
    check("mr ready", 32'(in_ready),  32'd1);
    check("mr sum",   32'(out_sum),   32'd0);
    check("mr count", 32'(out_count), 32'd0);
    send_beat(16'h0004, 1'b0, 1'b1);
    check_result("mr", 16'h0004, 1'b0, 1'b0, 1'b0, 4'd1);
    release_result("mr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
